mems_scan_sequencer: RTL

Parametrised MEMS mirror scan sequencer driving the DAC SPI master. After a soft-reset request it sends a configurable block of DAC init words, then streams scan points from the pattern ROM: one SPI word per point, pausable, optionally looping, with a go-home excursion. Line and frame markers come from internal point, line and frame counters rather than hard-coded addresses, and are handed to the acquisition FIFO logic as sticky flags with overrun detection.

---
 rtl/mems_scan_sequencer_if.sv | 22 ++
 rtl/mems_scan_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mems_scan_sequencer_if.sv
// rtl/mems_scan_sequencer_if.sv - ROM/SPI send and marker FIFO handshake bundle
interface mems_scan_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic              mems_SPI_start;
  logic              mems_SPI_busy;
  logic              new_line;
  logic              new_frame;
  logic              new_line_FIFO_done;
  logic              new_frame_FIFO_done;

  modport master (
    output rom_addr, mems_SPI_start, new_line, new_frame,
    input  mems_SPI_busy, new_line_FIFO_done, new_frame_FIFO_done
  );

  modport slave (
    input  rom_addr, mems_SPI_start, new_line, new_frame,
    output mems_SPI_busy, new_line_FIFO_done, new_frame_FIFO_done
  );
endinterface

// File: rtl/mems_scan_sequencer.sv
// rtl/mems_scan_sequencer.sv - MEMS mirror scan sequencer: DAC init block, point streaming, home park, markers
module mems_scan_sequencer #(
  parameter int ADDR_W          = 16,
  parameter int INIT_CMDS       = 2,
  parameter int SCAN_START      = 8,
  parameter int POINTS_PER_LINE = 800,
  parameter int LINES_PER_FRAME = 10,
  parameter int FRAMES          = 2,
  parameter int MARK_POS        = 615,
  parameter int HOME_ADDR       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mems_soft_reset_i,
  input  logic pause_i,
  input  logic loop_en_i,
  input  logic go_home_i,
  output logic marker_overrun_o,
  output logic scan_active_o,
  output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx_o,
  mems_scan_sequencer_if.master bus
);

  localparam int PW = (POINTS_PER_LINE > 1) ? $clog2(POINTS_PER_LINE) : 1;
  localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic [PW-1:0]     P_LAST     = PW'(POINTS_PER_LINE - 1);
  localparam logic [LW-1:0]     L_LAST     = LW'(LINES_PER_FRAME - 1);
  localparam logic [FW-1:0]     F_LAST     = FW'(FRAMES - 1);
  localparam logic [PW-1:0]     P_MARK     = PW'(MARK_POS);
  localparam logic [ADDR_W-1:0] INIT_LAST  = ADDR_W'(INIT_CMDS - 1);
  localparam logic [ADDR_W-1:0] SCAN_ADDR  = ADDR_W'(SCAN_START);
  localparam logic [ADDR_W-1:0] HOME_WORD  = ADDR_W'(HOME_ADDR);

  localparam longint PATTERN_END = longint'(SCAN_START)
                                 + longint'(FRAMES) * longint'(LINES_PER_FRAME) * longint'(POINTS_PER_LINE);

  if (INIT_CMDS < 1) begin : g_chk_init
    $error("INIT_CMDS must be at least 1");
  end
  if (POINTS_PER_LINE < 2 || LINES_PER_FRAME < 1 || FRAMES < 1) begin : g_chk_dims
    $error("pattern dimensions out of range");
  end
  if (MARK_POS >= POINTS_PER_LINE) begin : g_chk_mark
    $error("MARK_POS must be below POINTS_PER_LINE");
  end
  if (PATTERN_END > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("scan pattern does not fit in the ROM address space");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SCAN,
    ST_HOME,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              start_q, start_d;
  logic [PW-1:0]     point_q, point_d;
  logic [LW-1:0]     line_q, line_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              new_line_q, new_line_d;
  logic              new_frame_q, new_frame_d;
  logic              overrun_q, overrun_d;
  logic              scan_active_q, scan_active_d;

  logic issuable;
  logic last_point;
  logic do_init, do_next_init, do_restart, do_step, do_home;
  logic mark, set_line, set_frame;

  // A send needs the SPI master idle and one quiet cycle after the previous strobe.
  assign issuable   = !bus.mems_SPI_busy && !start_q;
  assign last_point = (point_q == P_LAST) && (line_q == L_LAST) && (frame_q == F_LAST);

  always_comb begin
    state_d      = state_q;
    do_init      = 1'b0;
    do_next_init = 1'b0;
    do_restart   = 1'b0;
    do_step      = 1'b0;
    do_home      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mems_soft_reset_i) do_init = 1'b1;
      end
      ST_INIT: begin
        if (issuable) begin
          if (rom_addr_q == INIT_LAST) do_restart   = 1'b1;
          else                         do_next_init = 1'b1;
        end
      end
      ST_SCAN: begin
        if (issuable) begin
          if (go_home_i) begin
            do_home = 1'b1;
          end else if (!pause_i) begin
            if (!last_point)    do_step    = 1'b1;
            else if (loop_en_i) do_restart = 1'b1;
            else                state_d    = ST_DONE;
          end
        end
      end
      ST_HOME: begin
        if (issuable && !go_home_i) do_restart = 1'b1;
      end
      ST_DONE: begin
        if (issuable && go_home_i) do_home = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Soft reset overrides every other action once the link is free.
    if (state_q != ST_IDLE && mems_soft_reset_i && issuable) begin
      do_next_init = 1'b0;
      do_restart   = 1'b0;
      do_step      = 1'b0;
      do_home      = 1'b0;
      do_init      = 1'b1;
    end

    if (do_restart || do_step) state_d = ST_SCAN;
    if (do_home)               state_d = ST_HOME;
    if (do_init)               state_d = ST_INIT;
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    start_d    = do_init | do_next_init | do_restart | do_step | do_home;
    point_d    = point_q;
    line_d     = line_q;
    frame_d    = frame_q;

    if (state_q == ST_IDLE || do_init) rom_addr_d = '0;
    if (do_next_init)                  rom_addr_d = rom_addr_q + 1'b1;
    if (do_home)                       rom_addr_d = HOME_WORD;

    if (do_restart) begin
      rom_addr_d = SCAN_ADDR;
      point_d    = '0;
      line_d     = '0;
      frame_d    = '0;
    end

    if (do_step) begin
      rom_addr_d = rom_addr_q + 1'b1;
      if (point_q == P_LAST) begin
        point_d = '0;
        if (line_q == L_LAST) begin
          line_d  = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          line_d = line_q + 1'b1;
        end
      end else begin
        point_d = point_q + 1'b1;
      end
    end
  end

  // Markers follow the counters of the point being sent on this edge.
  always_comb begin
    mark      = (do_restart || do_step) && (point_d == P_MARK);
    set_line  = mark && (line_d != '0);
    set_frame = mark && (line_d == '0);

    new_line_d  = set_line  ? 1'b1 : (bus.new_line_FIFO_done  ? 1'b0 : new_line_q);
    new_frame_d = set_frame ? 1'b1 : (bus.new_frame_FIFO_done ? 1'b0 : new_frame_q);

    overrun_d = overrun_q
              | (set_line  && new_line_q  && !bus.new_line_FIFO_done)
              | (set_frame && new_frame_q && !bus.new_frame_FIFO_done);
    if (do_init) overrun_d = 1'b0;

    scan_active_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rom_addr_q    <= '0;
      start_q       <= 1'b0;
      point_q       <= '0;
      line_q        <= '0;
      frame_q       <= '0;
      new_line_q    <= 1'b0;
      new_frame_q   <= 1'b0;
      overrun_q     <= 1'b0;
      scan_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      start_q       <= start_d;
      point_q       <= point_d;
      line_q        <= line_d;
      frame_q       <= frame_d;
      new_line_q    <= new_line_d;
      new_frame_q   <= new_frame_d;
      overrun_q     <= overrun_d;
      scan_active_q <= scan_active_d;
    end
  end

  assign bus.rom_addr       = rom_addr_q;
  assign bus.mems_SPI_start = start_q;
  assign bus.new_line       = new_line_q;
  assign bus.new_frame      = new_frame_q;
  assign marker_overrun_o   = overrun_q;
  assign scan_active_o      = scan_active_q;
  assign frame_idx_o        = frame_q;

endmodule
